// File: rtl/channel_playback_sched.sv
// channel_playback_sched: latches a playback job, waits for every selected
// channel buffer to prefill, starts all selected channels on one trigger,
// counts output beats, stops or loops at run end, flags underflow.
// Ports:
//   pl_clk, rst             clock, synchronous active-high reset
//   arm, cfg_*              job command and its configuration
//   trigger, abort          playback start / return to IDLE
//   ch_level, ch_tvalid     per-channel buffer fill level and output valid
//   ch_tready               per-channel DAC IP ready
//   ch_play_en              per-channel tvalid gate
//   state, busy, done       FSM state, not-IDLE flag, end-of-run pulse
//   loop_cnt                completed runs in loop mode (saturating)
//   underflow, prefill_tmo  sticky error flags
//   cmd_err                 pulse when an arm is rejected
module channel_playback_sched #(
    parameter int NUM_CH = 16,
    parameter int LEN_W  = 32,
    parameter int LVL_W  = 10,
    parameter int TMO_W  = 24
) (
    input  logic                    pl_clk,
    input  logic                    rst,
    input  logic                    arm,
    input  logic [NUM_CH-1:0]       cfg_mask,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic                    cfg_loop,
    input  logic [LVL_W-1:0]        cfg_prefill,
    input  logic [TMO_W-1:0]        cfg_timeout,
    input  logic                    trigger,
    input  logic                    abort,
    input  logic [NUM_CH*LVL_W-1:0] ch_level,
    input  logic [NUM_CH-1:0]       ch_tvalid,
    input  logic [NUM_CH-1:0]       ch_tready,
    output logic [NUM_CH-1:0]       ch_play_en,
    output logic [2:0]              state,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             loop_cnt,
    output logic [NUM_CH-1:0]       underflow,
    output logic                    prefill_tmo,
    output logic                    cmd_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFILL = 3'd1,
        S_ARMED   = 3'd2,
        S_PLAYING = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [NUM_CH-1:0]   r_mask;
    logic [LEN_W-1:0]    r_len;
    logic                r_loop;
    logic [LVL_W-1:0]    r_prefill;
    logic [TMO_W-1:0]    r_timeout;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [LEN_W-1:0]    r_beat;
    logic [15:0]         r_loop_cnt;
    logic [NUM_CH-1:0]   r_underflow;
    logic                r_prefill_tmo;
    logic                r_cmd_err;

    logic [NUM_CH-1:0]   w_filled;
    logic                w_all_filled;
    logic                w_tmo_hit;
    logic                w_beat;
    logic                w_last;
    logic                w_arm_ok;
    logic                w_arm_take;

    always_comb begin
        w_filled = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_filled[i] = (ch_level[i*LVL_W +: LVL_W] >= r_prefill);
        end
    end

    // Unmasked channels are forced true so they never block the AND-reduce.
    assign w_all_filled = &(w_filled | ~r_mask);
    assign w_beat       = &(ch_tready | ~r_mask);
    assign w_last       = (r_beat == r_len - LEN_W'(1));
    // Counter reaches the timeout on this edge.
    assign w_tmo_hit    = (r_timeout != '0) &&
                          (r_tmo_cnt == r_timeout - TMO_W'(1));
    assign w_arm_ok     = (cfg_mask != '0) && (cfg_len != '0);
    assign w_arm_take   = (r_state == S_IDLE) && arm && w_arm_ok;

    always_comb begin
        w_next = r_state;
        if (abort && r_state != S_IDLE) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm && w_arm_ok) w_next = S_PREFILL;
                end
                S_PREFILL: begin
                    if (w_all_filled)   w_next = S_ARMED;
                    else if (w_tmo_hit) w_next = S_IDLE;
                end
                S_ARMED: begin
                    if (trigger) w_next = S_PLAYING;
                end
                S_PLAYING: begin
                    if (w_beat && w_last && !r_loop) w_next = S_DONE;
                end
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge pl_clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_mask        <= '0;
            r_len         <= '0;
            r_loop        <= 1'b0;
            r_prefill     <= '0;
            r_timeout     <= '0;
            r_tmo_cnt     <= '0;
            r_beat        <= '0;
            r_loop_cnt    <= '0;
            r_underflow   <= '0;
            r_prefill_tmo <= 1'b0;
            r_cmd_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cmd_err <= (r_state == S_IDLE) && arm && !w_arm_ok;

            if (w_arm_take) begin
                r_mask        <= cfg_mask;
                r_len         <= cfg_len;
                r_loop        <= cfg_loop;
                r_prefill     <= cfg_prefill;
                r_timeout     <= cfg_timeout;
                r_tmo_cnt     <= '0;
                r_beat        <= '0;
                r_loop_cnt    <= '0;
                r_underflow   <= '0;
                r_prefill_tmo <= 1'b0;
            end

            if (r_state == S_PREFILL && !abort) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                if (w_tmo_hit && !w_all_filled) r_prefill_tmo <= 1'b1;
            end

            if (r_state == S_PLAYING) begin
                r_underflow <= r_underflow | (r_mask & ch_tready & ~ch_tvalid);
                if (!abort && w_beat) begin
                    if (w_last) begin
                        r_beat <= '0;
                        if (r_loop && r_loop_cnt != 16'hFFFF) begin
                            r_loop_cnt <= r_loop_cnt + 16'd1;
                        end
                    end else begin
                        r_beat <= r_beat + LEN_W'(1);
                    end
                end
            end
        end
    end

    // Decoded from registered state, so enable follows the trigger by one cycle.
    assign ch_play_en  = (r_state == S_PLAYING) ? r_mask : '0;
    assign state       = r_state;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign loop_cnt    = r_loop_cnt;
    assign underflow   = r_underflow;
    assign prefill_tmo = r_prefill_tmo;
    assign cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_channel_playback_sched.sv
// tb_channel_playback_sched: directed and randomized checks of
// channel_playback_sched against a beat-counting reference model.
module tb_channel_playback_sched;

    localparam int NUM_CH = 16;
    localparam int LEN_W  = 32;
    localparam int LVL_W  = 10;
    localparam int TMO_W  = 24;

    logic                    pl_clk = 1'b0;
    logic                    rst;
    logic                    arm;
    logic [NUM_CH-1:0]       cfg_mask;
    logic [LEN_W-1:0]        cfg_len;
    logic                    cfg_loop;
    logic [LVL_W-1:0]        cfg_prefill;
    logic [TMO_W-1:0]        cfg_timeout;
    logic                    trigger;
    logic                    abort;
    logic [NUM_CH*LVL_W-1:0] ch_level;
    logic [NUM_CH-1:0]       ch_tvalid;
    logic [NUM_CH-1:0]       ch_tready;
    logic [NUM_CH-1:0]       ch_play_en;
    logic [2:0]              state;
    logic                    busy;
    logic                    done;
    logic [15:0]             loop_cnt;
    logic [NUM_CH-1:0]       underflow;
    logic                    prefill_tmo;
    logic                    cmd_err;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: job parameters, beats seen in the current run,
    // completed runs, accumulated underflow, and which phase we expect.
    logic [15:0] m_mask;
    logic [15:0] m_uf;
    int          m_len;
    int          m_beats;
    int          m_runs;
    bit          m_loop;
    bit          m_playing;
    bit          m_done;
    int          n_en;
    int          n_done;

    channel_playback_sched #(
        .NUM_CH(NUM_CH), .LEN_W(LEN_W), .LVL_W(LVL_W), .TMO_W(TMO_W)
    ) dut (
        .pl_clk(pl_clk), .rst(rst), .arm(arm),
        .cfg_mask(cfg_mask), .cfg_len(cfg_len), .cfg_loop(cfg_loop),
        .cfg_prefill(cfg_prefill), .cfg_timeout(cfg_timeout),
        .trigger(trigger), .abort(abort), .ch_level(ch_level),
        .ch_tvalid(ch_tvalid), .ch_tready(ch_tready),
        .ch_play_en(ch_play_en), .state(state), .busy(busy), .done(done),
        .loop_cnt(loop_cnt), .underflow(underflow),
        .prefill_tmo(prefill_tmo), .cmd_err(cmd_err)
    );

    always #5 pl_clk = ~pl_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge pl_clk);
        @(negedge pl_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_state();
        if (m_playing) return 32'd3;
        if (m_done)    return 32'd4;
        return 32'd0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "/state"}, 32'(state), exp_state());
        chk({tag, "/busy"}, 32'(busy), 32'(exp_state() != 0));
        chk({tag, "/play_en"}, 32'(ch_play_en),
            m_playing ? 32'(m_mask) : 32'd0);
        chk({tag, "/done"}, 32'(done), 32'(m_done));
        chk({tag, "/underflow"}, 32'(underflow), 32'(m_uf));
        chk({tag, "/loop_cnt"}, 32'(loop_cnt), 32'(m_runs));
        chk({tag, "/cmd_err"}, 32'(cmd_err), 32'd0);
    endtask

    task automatic set_lvl(input int ch, input int v);
        ch_level[ch*LVL_W +: LVL_W] = LVL_W'(v);
    endtask

    task automatic set_all_lvl(input int v);
        for (int i = 0; i < NUM_CH; i++) set_lvl(i, v);
    endtask

    task automatic model_reset();
        m_mask = '0; m_uf = '0; m_len = 0; m_beats = 0; m_runs = 0;
        m_loop = 0; m_playing = 0; m_done = 0;
    endtask

    // One cycle of playback: drive handshakes, advance the model by the
    // rules (beat = every masked channel ready), then compare.
    task automatic play_cyc(input logic [15:0] rdy, input logic [15:0] vld);
        ch_tready = rdy;
        ch_tvalid = vld;
        if (m_done) begin
            m_done = 0;
        end else if (m_playing) begin
            m_uf |= m_mask & rdy & ~vld;
            if ((rdy & m_mask) == m_mask) begin
                m_beats++;
                if (m_beats == m_len) begin
                    m_beats = 0;
                    if (m_loop) begin
                        if (m_runs < 65535) m_runs++;
                    end else begin
                        m_playing = 0;
                        m_done = 1;
                    end
                end
            end
        end
        tick();
        if (ch_play_en != '0) n_en++;
        if (done) n_done++;
        check_all("play");
    endtask

    task automatic do_arm(input logic [15:0] mask, input int len,
                          input bit lp, input int pf, input int tmo);
        cfg_mask = mask; cfg_len = LEN_W'(len); cfg_loop = lp;
        cfg_prefill = LVL_W'(pf); cfg_timeout = TMO_W'(tmo);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        model_reset();
        m_mask = mask; m_len = len; m_loop = lp;
        chk("arm/state", 32'(state), 32'd1);
        chk("arm/cmd_err", 32'(cmd_err), 32'd0);
        chk("arm/prefill_tmo", 32'(prefill_tmo), 32'd0);
        chk("arm/underflow", 32'(underflow), 32'd0);
        chk("arm/loop_cnt", 32'(loop_cnt), 32'd0);
    endtask

    task automatic fill_and_arm(input int pf);
        set_all_lvl(pf);
        tick();
        chk("fill/state", 32'(state), 32'd2);
        chk("fill/play_en", 32'(ch_play_en), 32'd0);
    endtask

    task automatic do_trig();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        m_playing = 1;
        n_en = 0;
        n_done = 0;
        if (ch_play_en != '0) n_en++;
        check_all("trig");
    endtask

    task automatic do_abort();
        abort = 1'b1;
        ch_tready = '0;
        tick();
        abort = 1'b0;
        m_playing = 0;
        m_done = 0;
        check_all("abort");
    endtask

    task automatic do_reject(input logic [15:0] mask, input int len,
                             input string tag);
        cfg_mask = mask; cfg_len = LEN_W'(len);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk({tag, "/cmd_err"}, 32'(cmd_err), 32'd1);
        chk({tag, "/state"}, 32'(state), 32'd0);
        tick();
        chk({tag, "/cmd_err_end"}, 32'(cmd_err), 32'd0);
    endtask

    initial begin
        logic [15:0] rmask;
        int          rlen;
        bit          rloop;
        int          k;

        rst = 1'b1; arm = 1'b0; trigger = 1'b0; abort = 1'b0;
        cfg_mask = '0; cfg_len = '0; cfg_loop = 1'b0;
        cfg_prefill = '0; cfg_timeout = '0;
        ch_level = '0; ch_tvalid = '1; ch_tready = '1;
        model_reset();
        n_en = 0; n_done = 0;

        tick();
        tick();
        check_all("reset");
        chk("reset/prefill_tmo", 32'(prefill_tmo), 32'd0);
        rst = 1'b0;
        tick();
        check_all("idle");

        do_reject(16'h0000, 5, "rej_mask");
        do_reject(16'h0001, 0, "rej_len");

        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check_all("trig_idle");

        // Basic run
        set_all_lvl(0);
        do_arm(16'h0005, 4, 0, 8, 0);
        tick();
        chk("basic/prefill", 32'(state), 32'd1);
        set_lvl(0, 8);
        tick();
        chk("basic/half_fill", 32'(state), 32'd1);
        set_lvl(2, 8);
        tick();
        chk("basic/armed", 32'(state), 32'd2);
        do_trig();
        k = 0;
        while ((m_playing || m_done) && k < 20) begin
            play_cyc(16'hFFFF, 16'hFFFF);
            k++;
        end
        chk("basic/en_cycles", 32'(n_en), 32'd4);
        chk("basic/done_pulses", 32'(n_done), 32'd1);
        chk("basic/end_state", 32'(state), 32'd0);

        // Loop and abort
        do_arm(16'hFFFF, 3, 1, 4, 0);
        fill_and_arm(4);
        do_trig();
        repeat (10) play_cyc(16'hFFFF, 16'hFFFF);
        chk("loop/loop_cnt", 32'(loop_cnt), 32'd3);
        do_abort();
        chk("loop/no_done", 32'(n_done), 32'd0);

        // Underflow and stall; cfg changes and arm during play ignored
        do_arm(16'h0003, 5, 0, 8, 0);
        cfg_len = 32'd1; cfg_mask = 16'hFFFF; cfg_loop = 1'b1;
        fill_and_arm(8);
        do_trig();
        play_cyc(16'hFFFF, 16'hFFFD);
        play_cyc(16'hFFFF, 16'hFFFD);
        play_cyc(16'hFFFE, 16'hFFFF);
        cfg_mask = 16'h0000;
        arm = 1'b1;
        play_cyc(16'hFFFF, 16'hFFFF);
        arm = 1'b0;
        k = 0;
        while ((m_playing || m_done) && k < 20) begin
            play_cyc(16'hFFFF, 16'hFFFF);
            k++;
        end
        chk("uf/underflow", 32'(underflow), 32'h2);
        chk("uf/en_cycles", 32'(n_en), 32'd6);
        chk("uf/done_pulses", 32'(n_done), 32'd1);

        // Prefill timeout
        set_all_lvl(0);
        set_lvl(4, 15);
        do_arm(16'h0010, 8, 0, 16, 20);
        for (int i = 0; i < 19; i++) begin
            tick();
            chk("tmo/waiting", 32'(state), 32'd1);
        end
        chk("tmo/flag_early", 32'(prefill_tmo), 32'd0);
        tick();
        chk("tmo/state", 32'(state), 32'd0);
        chk("tmo/flag", 32'(prefill_tmo), 32'd1);
        chk("tmo/busy", 32'(busy), 32'd0);

        // Fill arrives on the timeout cycle: ARMED wins
        do_arm(16'h0010, 8, 0, 16, 20);
        repeat (19) tick();
        chk("tmo2/still_prefill", 32'(state), 32'd1);
        set_lvl(4, 16);
        tick();
        chk("tmo2/state", 32'(state), 32'd2);
        chk("tmo2/flag", 32'(prefill_tmo), 32'd0);

        // Abort and trigger together in ARMED
        abort = 1'b1;
        trigger = 1'b1;
        tick();
        abort = 1'b0;
        trigger = 1'b0;
        chk("abtrig/state", 32'(state), 32'd0);
        chk("abtrig/play_en", 32'(ch_play_en), 32'd0);
        tick();
        chk("abtrig/stay_idle", 32'(state), 32'd0);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            rmask = (16'd1 << $urandom_range(0, 15)) |
                    (16'd1 << $urandom_range(0, 15));
            rlen  = (j == 0) ? 1 : int'($urandom_range(1, 6));
            rloop = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            do_arm(rmask, rlen, rloop, 5, 0);
            fill_and_arm(5);
            do_trig();
            if (rloop) begin
                repeat (25) play_cyc(~(16'($urandom) & 16'($urandom)
                                       & 16'($urandom)),
                                     ~(16'($urandom) & 16'($urandom)));
                do_abort();
            end else begin
                k = 0;
                while ((m_playing || m_done) && k < 60) begin
                    play_cyc(~(16'($urandom) & 16'($urandom)
                               & 16'($urandom)),
                             ~(16'($urandom) & 16'($urandom)));
                    k++;
                end
                chk("rnd/end_state", 32'(state), 32'd0);
                if (m_playing || m_done) do_abort();
            end
        end

        // Reset mid-run
        do_arm(16'h0001, 100, 0, 4, 0);
        fill_and_arm(4);
        do_trig();
        play_cyc(16'hFFFF, 16'hFFFE);
        chk("rst/uf_before", 32'(underflow), 32'h1);
        rst = 1'b1;
        tick();
        model_reset();
        check_all("rst_mid");
        chk("rst/prefill_tmo", 32'(prefill_tmo), 32'd0);
        rst = 1'b0;
        tick();
        check_all("rst_after");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
